// File: rtl/zx_kbd_port.sv
// ZX Spectrum keyboard port (ULA port FE read path).
// Raw key matrix and EAR are synchronised. Each key is then debounced on its own.
// The rows selected by ad[15:8] are ANDed into the key bits.
// The byte is latched on the rising edge of ce&&rd and driven onto data_bus while the read lasts.
// Optional: define ZX_KBD_KEMPSTON_EN to add a Kempston joystick input,
// which is read when ad[7:0] == 8'h1F.
module zx_kbd_port #(
  parameter int unsigned COLS       = 5,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              rd,
  input  logic [15:0]       ad,
  inout  wire  [7:0]        data_bus,
  input  logic [8*COLS-1:0] keys_n,
`ifdef ZX_KBD_KEMPSTON_EN
  input  logic [4:0]        joy,
`endif
  input  logic              ear
);

  localparam int unsigned NK = 8 * COLS;
  localparam int unsigned CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CntLast = CW'(DEB_CYCLES - 1);

  logic [NK-1:0] keys_s1_q, keys_s2_q;
  logic          ear_s1_q, ear_s2_q;
  logic [NK-1:0] deb_q;
  logic [CW-1:0] cnt_q [NK];
  logic [7:0]    rd_q;
  logic          valid_q;  // byte captured for the current read; bus may be driven
  logic          armed_q;  // ce&&rd seen low since last capture (or since reset)
  logic [4:0]    key_bits;
  logic [7:0]    assembled;
  logic          rd_act;

  assign rd_act = ce && rd;

  // Two-flop synchronisers for the asynchronous matrix and EAR inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keys_s1_q <= '1;
      keys_s2_q <= '1;
      ear_s1_q  <= 1'b1;
      ear_s2_q  <= 1'b1;
    end else begin
      keys_s1_q <= keys_n;
      keys_s2_q <= keys_s1_q;
      ear_s1_q  <= ear;
      ear_s2_q  <= ear_s1_q;
    end
  end

  // Per-key debounce: accept a new level after DEB_CYCLES consecutive differing clocks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q <= '1;
      for (int i = 0; i < NK; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NK; i++) begin
        if (keys_s2_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CntLast) begin
            deb_q[i] <= keys_s2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

`ifdef ZX_KBD_KEMPSTON_EN
  logic [4:0] joy_s1_q, joy_s2_q;

  // Joystick synchroniser; idles released (0) because the inputs are active-high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      joy_s1_q <= '0;
      joy_s2_q <= '0;
    end else begin
      joy_s1_q <= joy;
      joy_s2_q <= joy_s1_q;
    end
  end
`else
  logic unused_ad_low;
  assign unused_ad_low = ^ad[7:0];
`endif

  // Assemble the port byte from the selected rows, EAR and the fixed-high bits
  always_comb begin
    key_bits = '1;
    for (int r = 0; r < 8; r++) begin
      if (!ad[8+r]) begin
        for (int c = 0; c < COLS; c++) key_bits[c] = key_bits[c] & deb_q[r*COLS+c];
      end
    end
    assembled = {1'b1, ear_s2_q, 1'b1, key_bits};
`ifdef ZX_KBD_KEMPSTON_EN
    if (ad[7:0] == 8'h1F) assembled = {3'b000, joy_s2_q};
`endif
  end

  // Read latch: capture on the first ce&&rd clock, freeze until ce&&rd drops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q    <= 8'hFF;
      valid_q <= 1'b0;
      armed_q <= 1'b0;  // a read held through reset must end before a new one counts
    end else if (rd_act) begin
      if (armed_q) begin
        rd_q    <= assembled;
        valid_q <= 1'b1;
        armed_q <= 1'b0;
      end
    end else begin
      valid_q <= 1'b0;
      armed_q <= 1'b1;
    end
  end

  assign data_bus = (rd_act && valid_q) ? rd_q : 8'hzz;

endmodule
